sort_unload: RTL and testbench
==============================

SORT_UNLOAD -- requirements
Module: sort_unload

Interface
REQ-001 Parameter K, default 8, number of memory words to unload (K >= 2).
REQ-002 Parameter N, default 8, data word width in bits.
REQ-003 Parameter AW, default $clog2(K), memory address width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 done_in  input  1  sort-complete level from the sort controller.
REQ-007 mem_addr  output  AW  registered read address into the sorted memory.
REQ-008 mem_re  output  1  read-issue strobe; mem_rdata is valid exactly one cycle after mem_re=1.
REQ-009 mem_rdata  input  N  memory read data.
REQ-010 out_data  output  N  streamed sorted word.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accept; handshake = out_valid & out_ready.
REQ-013 out_last  output  1  high with the word read from address K-1.
REQ-014 busy  output  1  high in any state other than IDLE and DONE.
REQ-015 unload_done  output  1  one-cycle pulse after the final handshake.
REQ-016 order_err  output  1  sticky ascending-order violation flag (see Configuration).

Function
REQ-017 FSM states are IDLE, READ, DRAIN and DONE.
REQ-018 IDLE: when done_in=1, go to READ; rd_addr=0, word count=0, buffer empty.
REQ-019 READ: issue a read (mem_re=1, mem_addr=rd_addr, rd_addr++) in any cycle where rd_addr<K and buffer_count+inflight-pop < 2.
REQ-020 Buffer is a 2-entry FIFO; mem_rdata is pushed the cycle after mem_re; the buffer never overflows.
REQ-021 READ goes to DRAIN in the cycle the read of address K-1 is issued.
REQ-022 DRAIN goes to DONE on the handshake of the K-th word; unload_done=1 for exactly that next cycle.
REQ-023 DONE stays in DONE while done_in=1 and returns to IDLE when done_in=0, so one sort produces exactly one unload.
REQ-024 out_valid = buffer non-empty; out_data = FIFO head.
REQ-025 out_valid and out_data hold stable while out_valid=1 and out_ready=0.
REQ-026 Latency: done_in sampled high at cycle T gives mem_re at T+1 and out_valid at T+3.
REQ-027 With out_ready held high, one word transfers per cycle after the first; K words complete at T+K+2.
REQ-028 Push and pop in the same cycle are legal at any occupancy.
REQ-029 out_last=1 exactly when the head is the word read from address K-1.
REQ-030 done_in falling mid-unload is ignored; the unload completes.
REQ-031 rd_addr never exceeds K-1 on mem_addr; no read is issued in DRAIN, DONE or IDLE.

Reset
REQ-032 rst forces IDLE and zeros mem_addr, mem_re, out_data, out_valid, out_last, busy, unload_done, order_err, counters and buffer.
REQ-033 rst asserted mid-unload discards buffered and in-flight data, and the returning read data is not pushed.
REQ-034 After rst with done_in still high, a fresh unload starts from address 0.

Configuration
REQ-035 Macro SORT_UNLOAD_CHECK_EN enables the order checker.
REQ-036 With SORT_UNLOAD_CHECK_EN: each handshaked word is compared with the previous one, and order_err is set if it is smaller than the previous word (unsigned); order_err clears only on rst or the next IDLE-to-READ transition.
REQ-037 Without SORT_UNLOAD_CHECK_EN: order_err is constant 0 and no comparator or previous-word register exists.

Verification
REQ-038 K=8, memory {1..8}, out_ready=1, done_in at T: out_valid at T+3, words 1..8 on consecutive cycles, out_last with 8, unload_done at T+11.
REQ-039 Memory {1..8}, out_ready toggled 1,0,0,1 repeating: all 8 words in order, none dropped or duplicated, data stable while stalled.
REQ-040 rst pulsed after 3 handshakes: outputs zero next cycle; done_in still high restarts an unload from address 0.
REQ-041 done_in held high after completion: stays in DONE with no second unload; done_in low then high runs a new unload.
REQ-042 CHECK_EN, memory {1,2,5,3,6,7,8,9}: order_err rises after the handshake of word 3 and stays high; without the macro it stays 0.
REQ-043 out_ready=0 for 20 cycles at start: mem_re issued at most twice, buffer holds words 1 and 2, no further reads until a pop.

Source files
------------

// File: rtl/sort_unload.sv
// sort_unload
//
// Streams the K words of a sorted memory out over a valid/ready port once
// the sort controller raises done_in. Reads are issued only when the 2-entry
// output FIFO is guaranteed to have room when the data arrives, so a stalled
// consumer never causes data loss. One unload runs per rising done_in: the
// FSM parks in DONE until done_in falls.
//
// Optional feature: define SORT_UNLOAD_CHECK_EN to build an ascending-order
// checker that raises the sticky order_err flag. Without it order_err is 0.
//
// Parameters:
//   K   number of memory words to unload (K >= 2)
//   N   data word width
//   AW  memory address width
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   done_in      sort-complete level
//   mem_addr     registered read address
//   mem_re       read strobe, mem_rdata valid the following cycle
//   mem_rdata    memory read data
//   out_data     streamed word (FIFO head)
//   out_valid    out_data valid
//   out_ready    downstream accept
//   out_last     head is the word read from address K-1
//   busy         unload in progress (READ or DRAIN)
//   unload_done  one-cycle pulse after the final handshake
//   order_err    sticky order violation flag
module sort_unload #(
    parameter int K  = 8,
    parameter int N  = 8,
    parameter int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done_in,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [N-1:0]  mem_rdata,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          unload_done,
    output logic          order_err
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(K - 1);

    state_t         state;
    logic [AW-1:0]  rd_addr;
    logic           rvalid;
    logic           rlast;
    logic [N-1:0]   buf_data [2];
    logic           buf_last [2];
    logic           wptr;
    logic           rptr;
    logic [1:0]     count;
    logic           push;
    logic           pop;
    logic [2:0]     committed;

    assign push      = rvalid;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = buf_data[rptr];
    assign out_last  = buf_last[rptr] & out_valid;
    assign mem_addr  = rd_addr;
    assign busy      = (state == READ) || (state == DRAIN);

    // Slots that will be occupied once the read now in flight lands, after
    // this cycle's pop. A new read is only issued if one more slot is free
    // when it returns, which keeps full throughput with out_ready high.
    assign committed = {1'b0, count} + {2'b00, rvalid} - {2'b00, pop};
    assign mem_re    = (state == READ) && (committed < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_addr     <= '0;
            rvalid      <= 1'b0;
            rlast       <= 1'b0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            count       <= 2'd0;
            unload_done <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            // read pipeline: data of a read issued now is pushed next cycle,
            // tagged with whether it came from the final address
            rvalid <= mem_re;
            rlast  <= mem_re && (rd_addr == LAST_ADDR);

            if (push) begin
                buf_data[wptr] <= mem_rdata;
                buf_last[wptr] <= rlast;
                wptr           <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            unload_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_in) begin
                        state   <= READ;
                        rd_addr <= '0;
                    end
                end
                READ: begin
                    // the address stays at K-1 on the last read so mem_addr
                    // never leaves the memory range
                    if (mem_re) begin
                        if (rd_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state       <= DONE;
                        rd_addr     <= '0;
                        unload_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!done_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SORT_UNLOAD_CHECK_EN
    logic [N-1:0] prev_word;
    logic         have_prev;

    // compares each accepted word with the previously accepted one; the
    // first word of an unload has nothing to compare against
    always_ff @(posedge clk) begin
        if (rst) begin
            order_err <= 1'b0;
            prev_word <= '0;
            have_prev <= 1'b0;
        end else if (state == IDLE && done_in) begin
            order_err <= 1'b0;
            have_prev <= 1'b0;
        end else if (pop) begin
            if (have_prev && (out_data < prev_word)) begin
                order_err <= 1'b1;
            end
            prev_word <= out_data;
            have_prev <= 1'b1;
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_unload.sv
// tb_sort_unload
//
// Self-checking bench for sort_unload (K=8, N=8). A table of scenarios
// (memory image, out_ready pattern, optional initial stall, timing check)
// is run through applyStimulus; the expected word stream is queued when
// done_in is raised and popped on every handshake. Hand-written sequences
// cover reset in the middle of an unload and reset values.
module tb_sort_unload;

    localparam int K  = 8;
    localparam int N  = 8;
    localparam int AW = $clog2(K);

    logic          clk;
    logic          rst;
    logic          done_in;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [N-1:0]  mem_rdata;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          unload_done;
    logic          order_err;

    sort_unload #(.K(K), .N(N), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .done_in    (done_in),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .unload_done(unload_done),
        .order_err  (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [K*N-1:0] img;
        logic [3:0]     mask;
        logic           timing;
        logic [7:0]     stall;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] d;
        logic         l;
    } exp_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    exp_t         sbq[$];
    exp_t         e;
    logic [N-1:0] memarr [K];
    int           expAddr, reCount, hsCount, firstRe, firstVal, doneCyc;
    bit           sbEn = 1'b0;
    logic         modelErr, havePrev, prevStall;
    logic [N-1:0] prevW, stallData;
    vec_t         vecs [6];

    always @(posedge clk) cyc++;

    // memory model: registered read, garbage when no read was issued
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= memarr[mem_addr];
        else        mem_rdata <= 8'hEE;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [K*N-1:0] img8(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic expErrOf(input logic [K*N-1:0] img);
        logic err;
        err = 1'b0;
`ifdef SORT_UNLOAD_CHECK_EN
        for (int i = 1; i < K; i++)
            if (img[i*N +: N] < img[(i-1)*N +: N]) err = 1'b1;
`endif
        return err;
    endfunction

    // monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (sbEn && !rst) begin
            if (mem_re) begin
                reCount++;
                if (firstRe < 0) firstRe = cyc;
                checkOutput("read_addr", 32'(mem_addr), 32'(expAddr));
                expAddr++;
            end
            if (out_valid && firstVal < 0) firstVal = cyc;
            if (prevStall) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_data", 32'(out_data), 32'(stallData));
            end
            prevStall = out_valid && !out_ready;
            stallData = out_data;
            if (busy) checkOutput("order_err_live", 32'(order_err), 32'(modelErr));
            if (out_valid && out_ready) begin
                hsCount++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra_word: got %0h expected none", out_data);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("data", 32'(out_data), 32'(e.d));
                    checkOutput("last", 32'(out_last), 32'(e.l));
                end
`ifdef SORT_UNLOAD_CHECK_EN
                if (havePrev && out_data < prevW) modelErr = 1'b1;
`endif
                prevW = out_data;
                havePrev = 1'b1;
            end
            if (unload_done && doneCyc < 0) doneCyc = cyc;
        end
    end

    task automatic loadExpected(input logic [K*N-1:0] img);
        sbq.delete();
        for (int i = 0; i < K; i++) begin
            memarr[i] = img[i*N +: N];
            sbq.push_back({img[i*N +: N], (i == K-1)});
        end
        expAddr = 0; reCount = 0; hsCount = 0;
        firstRe = -1; firstVal = -1; doneCyc = -1;
        modelErr = 1'b0; havePrev = 1'b0; prevStall = 1'b0;
        sbEn = 1'b1;
    endtask

    task automatic waitDone(input logic [3:0] mask);
        int n;
        int ph;
        n = 0;
        ph = 0;
        while (doneCyc < 0 && n < 300) begin
            out_ready = mask[ph % 4];
            ph++;
            @(posedge clk); #1;
            n++;
        end
        if (doneCyc < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unload_timeout: got no unload_done expected pulse within 300 cycles");
        end
    endtask

    task automatic finishRun(input logic [K*N-1:0] img);
        checkOutput("queue_empty", 32'(sbq.size()), 32'd0);
        checkOutput("order_err_final", 32'(order_err), 32'(expErrOf(img)));
        // done_in held high: must stay in DONE without a second unload
        repeat (10) begin @(posedge clk); #1; end
        checkOutput("reads_total", 32'(reCount), 32'(K));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        done_in = 1'b0;
        out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic applyStimulus(input vec_t v);
        int c0;
        loadExpected(v.img);
        @(posedge clk); #1;
        c0 = cyc;
        done_in = 1'b1;
        out_ready = 1'b0;
        if (v.stall != 0) begin
            repeat (int'(v.stall)) begin @(posedge clk); #1; end
            checkOutput("stall_reads", 32'(reCount), 32'd2);
            checkOutput("stall_head_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_head_data", 32'(out_data), 32'(v.img[N-1:0]));
        end
        waitDone(v.mask);
        if (v.timing) begin
            checkOutput("first_re_cycle", 32'(firstRe), 32'(c0 + 1));
            checkOutput("first_valid_cycle", 32'(firstVal), 32'(c0 + 3));
            checkOutput("done_cycle", 32'(doneCyc), 32'(c0 + K + 3));
        end
        finishRun(v.img);
    endtask

    task automatic resetMidUnload();
        int n;
        logic [K*N-1:0] img;
        img = img8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        loadExpected(img);
        @(posedge clk); #1;
        done_in = 1'b1;
        n = 0;
        while (hsCount < 3 && n < 50) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        checkOutput("handshakes_before_rst", 32'(hsCount), 32'd3);
        sbEn = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_mem_re", 32'(mem_re), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_unload_done", 32'(unload_done), 32'd0);
        rst = 1'b0;
        // done_in is still high, so a complete unload from address 0 follows
        loadExpected(img);
        waitDone(4'b1111);
        finishRun(img);
    endtask

    initial begin
        rst = 1'b1;
        done_in = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < K; i++) memarr[i] = '0;

        vecs[0] = '{img: img8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), mask: 4'b1111, timing: 1'b1, stall: 8'd0};
        vecs[1] = '{img: img8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), mask: 4'b1001, timing: 1'b0, stall: 8'd0};
        vecs[2] = '{img: img8(8'd1, 8'd2, 8'd5, 8'd3, 8'd6, 8'd7, 8'd8, 8'd9), mask: 4'b1111, timing: 1'b0, stall: 8'd0};
        vecs[3] = '{img: img8(8'h00, 8'h00, 8'h7f, 8'h80, 8'h80, 8'hfe, 8'hff, 8'hff), mask: 4'b0110, timing: 1'b0, stall: 8'd0};
        vecs[4] = '{img: img8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), mask: 4'b1111, timing: 1'b0, stall: 8'd20};
        vecs[5] = '{img: img8(8'd9, 8'd4, 8'd10, 8'd11, 8'd12, 8'd13, 8'd20, 8'd30), mask: 4'b1010, timing: 1'b0, stall: 8'd0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_mem_re", 32'(mem_re), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_order_err", 32'(order_err), 32'd0);
        checkOutput("reset_unload_done", 32'(unload_done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] scenario %0d", i);
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset in the middle of an unload");
        resetMidUnload();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
